bmf_code_search: RTL
====================

BMF_CODE_SEARCH -- requirements
Module: bmf_code_search

Interface
REQ-001 Parameter K, default 3, SHALL set the latent code width in bits (range 1..6).
REQ-002 Parameter M, default 4, SHALL set the output vector width in bits (range 1..16).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 cfg_we  input  1  SHALL be the write strobe for one row of the decompressor matrix H.
REQ-006 cfg_addr  input  clog2(K) (min 1)  SHALL select H row index 0..K-1.
REQ-007 cfg_wdata  input  M  SHALL be the row value written to H[cfg_addr].
REQ-008 cfg_drop  output  1  SHALL pulse high for one cycle when a cfg write is dropped.
REQ-009 tgt_valid / tgt_ready  input / output  1 each  SHALL be the target-vector handshake.
REQ-010 tgt_data  input  M  SHALL be the exact output vector to be encoded.
REQ-011 code_valid / code_ready  output / input  1 each  SHALL be the result handshake.
REQ-012 code_data  output  K  SHALL be the best latent code found.
REQ-013 code_recon  output  M  SHALL be H-product of code_data (reconstructed vector).
REQ-014 code_err  output  clog2(M+1)  SHALL be Hamming distance between code_recon and target.

Function
REQ-015 recon(c) SHALL be the combination over rows i with c[i]=1 of H[i]; OR semiring by default (see REQ-031); c=0 gives all-zero.
REQ-016 FSM SHALL have states IDLE, SEARCH, DONE; tgt_ready=1 only in IDLE.
REQ-017 IDLE->SEARCH on tgt_valid&tgt_ready; tgt_data SHALL be captured in that cycle.
REQ-018 SEARCH SHALL evaluate one candidate per cycle, c=0,1,...,2^K-1, with no early exit.
REQ-019 Best-so-far SHALL update only on strictly smaller error; ties keep the lowest code.
REQ-020 SEARCH->DONE after candidate 2^K-1; code_valid SHALL rise exactly 2^K+1 cycles after the accepting edge (9 for K=3).
REQ-021 In DONE, code_valid=1 and code_data/recon/err SHALL hold stable until code_valid&code_ready, then ->IDLE.
REQ-022 No new target accepted in the cycle code is consumed; earliest next accept is the following cycle.
REQ-023 cfg_we in IDLE SHALL write H[cfg_addr] at the edge; in SEARCH/DONE the write SHALL be ignored and cfg_drop pulse.
REQ-024 cfg_addr >= K SHALL be ignored and SHALL pulse cfg_drop.
REQ-025 cfg_we coincident with tgt accept SHALL be honoured (still IDLE); search uses the newly written row.
REQ-026 code_err width SHALL hold M without overflow; error arithmetic is unsigned popcount of XOR.

Reset
REQ-027 rst SHALL force state IDLE, all H rows 0, captured target 0, best code/err registers 0.
REQ-028 After reset: tgt_ready=1, code_valid=0, code_data=0, code_recon=0, code_err=0, cfg_drop=0.
REQ-029 rst asserted mid-SEARCH or in DONE SHALL abort; the pending result is discarded, never presented.
REQ-030 rst SHALL take priority over any same-cycle cfg_we or handshake.

Configuration
REQ-031 Macro BMF_XOR_SEMIRING_EN defined: recon(c) SHALL use XOR (GF(2)) accumulation of selected rows; undefined: OR (Boolean) accumulation. Interface, latency, tie rule unchanged.

Structure
REQ-032 A shared package bmf_pkg SHALL hold the FSM state enum, default K/M constants and a popcount function.
REQ-033 One sub-module bmf_recon (combinational H-row selector/accumulator, macro-aware) SHALL be instantiated once.

Verification (K=3, M=4; H0=0001, H1=0010, H2=1100 unless noted)
REQ-034 Reset then target 1101 -> code_data=101, code_recon=1101, code_err=0, code_valid at cycle 9.
REQ-035 Target 1010 -> code_data=010, code_recon=0010, code_err=1 (lowest code among err=1 ties).
REQ-036 H0=0011, H1=0110, H2=1100, target 0101 -> OR build: code 011, recon 0111, err 1; XOR build: code 011, recon 0101, err 0.
REQ-037 cfg_we during SEARCH and cfg_addr=3 in IDLE -> cfg_drop pulses once each, H unchanged, result identical to REQ-034.
REQ-038 Hold code_ready=0 for 5 cycles in DONE -> outputs stable, tgt_ready=0; rst in cycle 4 of SEARCH -> code_valid never rises, tgt_ready=1 next cycle.

Source files
------------

// File: rtl/bmf_pkg.sv
// Shared types and helpers for the BMF latent-code search block.
// Consumers honour BMF_XOR_SEMIRING_EN (XOR vs OR row accumulation) where relevant.
package bmf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  localparam int unsigned K_DEF = 3;
  localparam int unsigned M_DEF = 4;
  localparam int unsigned POP_W = 16;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bmf_recon.sv
// Combinational H-product: accumulates the H rows selected by the set bits of code_i.
// BMF_XOR_SEMIRING_EN selects GF(2) accumulation; otherwise Boolean OR.
module bmf_recon
  import bmf_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned M = M_DEF
) (
  input  logic [K-1:0][M-1:0] h_i,
  input  logic [K-1:0]        code_i,
  output logic [M-1:0]        recon_o
);

  logic [M-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (code_i[i]) begin
`ifdef BMF_XOR_SEMIRING_EN
        acc = acc ^ h_i[i];
`else
        acc = acc | h_i[i];
`endif
      end
    end
    recon_o = acc;
  end

endmodule

// File: rtl/bmf_code_search.sv
// Exhaustive search for the latent code whose H-product best matches a target vector.
// Accumulation semiring follows BMF_XOR_SEMIRING_EN (see bmf_recon).
module bmf_code_search
  import bmf_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned M = M_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_we,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0] cfg_addr,
  input  logic [M-1:0]                         cfg_wdata,
  output logic                                 cfg_drop,
  input  logic                                 tgt_valid,
  output logic                                 tgt_ready,
  input  logic [M-1:0]                         tgt_data,
  output logic                                 code_valid,
  input  logic                                 code_ready,
  output logic [K-1:0]                         code_data,
  output logic [M-1:0]                         code_recon,
  output logic [$clog2(M+1)-1:0]               code_err
);

  localparam int unsigned EW = $clog2(M + 1);

  state_e             state_q;
  logic [K-1:0][M-1:0] h_q;
  logic [M-1:0]       tgt_q;
  logic [K:0]         cnt_q;
  logic [K-1:0]       best_code_q;
  logic [M-1:0]       best_recon_q;
  logic [EW-1:0]      best_err_q;
  logic               valid_q;
  logic               drop_q;

  logic [K-1:0]       cand_code;
  logic [M-1:0]       cand_recon;
  logic [POP_W-1:0]   cand_diff;
  logic [EW-1:0]      cand_err;
  logic               cfg_ok;

  assign cand_code = cnt_q[K-1:0];
  assign cand_diff = POP_W'(cand_recon ^ tgt_q);
  assign cand_err  = EW'(popcount(cand_diff));
  assign cfg_ok    = (state_q == IDLE) && (32'(cfg_addr) < K);

  bmf_recon #(
    .K(K),
    .M(M)
  ) u_recon (
    .h_i    (h_q),
    .code_i (cand_code),
    .recon_o(cand_recon)
  );

  // cnt_q walks 0..2^K-1 through the candidates; its top bit marks the extra
  // cycle that hands the best result over to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      h_q          <= '0;
      tgt_q        <= '0;
      cnt_q        <= '0;
      best_code_q  <= '0;
      best_recon_q <= '0;
      best_err_q   <= '0;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      drop_q <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) h_q[cfg_addr] <= cfg_wdata;

      case (state_q)
        IDLE: begin
          if (tgt_valid) begin
            tgt_q   <= tgt_data;
            cnt_q   <= '0;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (cnt_q[K]) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            if ((cnt_q == '0) || (cand_err < best_err_q)) begin
              best_code_q  <= cand_code;
              best_recon_q <= cand_recon;
              best_err_q   <= cand_err;
            end
            cnt_q <= cnt_q + (K + 1)'(1);
          end
        end
        DONE: begin
          if (code_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tgt_ready  = (state_q == IDLE);
  assign code_valid = valid_q;
  assign code_data  = best_code_q;
  assign code_recon = best_recon_q;
  assign code_err   = best_err_q;
  assign cfg_drop   = drop_q;

endmodule
